output_layer_mac: RTL and testbench

//  Output (second) dense layer of the digit classifier: buffers 30 hidden-layer activations, computes
//  10 neuron scores = bias + sum(w*a) with one time-shared MAC, and reports the argmax as the digit.

---
 rtl/nn_pkg.sv | 32 +++
 rtl/mac_unit.sv | 32 +++
 rtl/output_layer_mac.sv | 131 +++++++++++++
 tb/tb_output_layer_mac.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared parameters and types for the digit classifier output layer.
// Widths, state encoding and the bias alignment helper live here.
package nn_pkg;

  localparam int N_IN      = 30;
  localparam int N_OUT     = 10;
  localparam int DATA_W    = 8;
  localparam int FRAC_BITS = 4;
  localparam int ACC_W     = 24;

  localparam int IDX_W = $clog2(N_IN + 1);
  localparam int NEU_W = $clog2(N_OUT);

  localparam logic [IDX_W-1:0] LAST_K   = IDX_W'(N_IN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
  localparam logic [NEU_W-1:0] LAST_N   = NEU_W'(N_OUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    MAC,
    DONE
  } state_t;

  // Bias is in activation scale; products carry twice the fraction bits.
  function automatic logic signed [ACC_W-1:0] bias_align(
    input logic signed [DATA_W-1:0] b
  );
    return ACC_W'(b) <<< FRAC_BITS;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Registered signed multiply-accumulate with synchronous load.
// sum is the value the accumulator takes on the next accumulate edge.
module mac_unit
  import nn_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load,
  input  logic                     en,
  input  logic signed [ACC_W-1:0]  init,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] a,
  output logic signed [ACC_W-1:0]  sum
);

  logic signed [ACC_W-1:0]    acc;
  logic signed [2*DATA_W-1:0] prod;

  assign prod = w * a;
  assign sum  = acc + ACC_W'(prod);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc <= '0;
    end else if (load) begin
      acc <= init;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/output_layer_mac.sv
// Output dense layer: buffers hidden activations, scores each digit
// with one shared MAC and reports the argmax digit.
module output_layer_mac
  import nn_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [DATA_W-1:0]                      act_in,
  input  logic                                   act_valid,
  output logic                                   act_ready,
  input  logic [N_OUT-1:0][N_IN-1:0][DATA_W-1:0] weights_HL,
  input  logic [N_OUT-1:0][DATA_W-1:0]           biases_HL,
  output logic [N_OUT-1:0][ACC_W-1:0]            scores,
  output logic [3:0]                             digit,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic                                   busy
);

  state_t                  state;
  logic [IDX_W-1:0]        in_idx;
  logic [IDX_W-1:0]        k;
  logic [NEU_W-1:0]        n;
  logic signed [DATA_W-1:0] act_buf [N_IN];
  logic signed [ACC_W-1:0]  max_score;

  logic                     mac_load;
  logic                     mac_en;
  logic signed [ACC_W-1:0]  mac_bias;
  logic signed [DATA_W-1:0] mac_w;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [ACC_W-1:0]  sum;
  logic                     take;

  // k=0 seeds the bias, k=1..N_IN accumulate element k-1.
  always_comb begin
    mac_load = (state == MAC) && (k == '0);
    mac_en   = (state == MAC) && (k != '0);
    mac_bias = bias_align(biases_HL[n]);
    mac_w    = '0;
    mac_a    = '0;
    if (mac_en) begin
      mac_w = weights_HL[n][k - 1'b1];
      mac_a = act_buf[k - 1'b1];
    end
  end

  assign take = (n == '0) || (sum > max_score);

  mac_unit u_mac (
    .clk   (clk),
    .reset (reset),
    .load  (mac_load),
    .en    (mac_en),
    .init  (mac_bias),
    .w     (mac_w),
    .a     (mac_a),
    .sum   (sum)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      act_ready <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      scores    <= '0;
      digit     <= '0;
      in_idx    <= '0;
      k         <= '0;
      n         <= '0;
      max_score <= '0;
      for (int i = 0; i < N_IN; i++) begin
        act_buf[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (act_valid) begin
            act_buf[0] <= act_in;
            in_idx     <= IDX_W'(1);
            state      <= LOAD;
          end
        end
        LOAD: begin
          if (act_valid) begin
            act_buf[in_idx] <= act_in;
            if (in_idx == LAST_IDX) begin
              in_idx    <= '0;
              k         <= '0;
              n         <= '0;
              act_ready <= 1'b0;
              busy      <= 1'b1;
              state     <= MAC;
            end else begin
              in_idx <= in_idx + 1'b1;
            end
          end
        end
        MAC: begin
          if (k == LAST_K) begin
            scores[n] <= sum;
            if (take) begin
              max_score <= sum;
              digit     <= 4'(n);
            end
            k <= '0;
            if (n == LAST_N) begin
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              n <= n + 1'b1;
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            act_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_layer_mac.sv
// Self-checking bench for output_layer_mac against an arithmetic
// reference of the dense layer (bias*16 + sum of products, argmax).
module tb_output_layer_mac;

  localparam int NI = 30;
  localparam int NO = 10;

  logic                     clk;
  logic                     reset;
  logic [7:0]               act_in;
  logic                     act_valid;
  logic                     act_ready;
  logic [NO-1:0][NI-1:0][7:0] weights_HL;
  logic [NO-1:0][7:0]       biases_HL;
  logic [NO-1:0][23:0]      scores;
  logic [3:0]               digit;
  logic                     out_valid;
  logic                     out_ready;
  logic                     busy;

  int checks;
  int errors;

  int w [NO][NI];
  int b [NO];
  int a [NI];
  int exp_s [NO];
  int exp_d;

  int  cyc;
  bit  seen_ready;
  bit  seen_idle;

  output_layer_mac dut (
    .clk        (clk),
    .reset      (reset),
    .act_in     (act_in),
    .act_valid  (act_valid),
    .act_ready  (act_ready),
    .weights_HL (weights_HL),
    .biases_HL  (biases_HL),
    .scores     (scores),
    .digit      (digit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  function automatic int got_score(input int idx);
    logic signed [23:0] v;
    v = scores[idx];
    return int'(v);
  endfunction

  task automatic model();
    exp_d = 0;
    for (int n = 0; n < NO; n++) begin
      exp_s[n] = b[n] * 16;
      for (int i = 0; i < NI; i++) exp_s[n] += w[n][i] * a[i];
      if (n > 0 && exp_s[n] > exp_s[exp_d]) exp_d = n;
    end
  endtask

  task automatic load_ports();
    for (int n = 0; n < NO; n++) begin
      biases_HL[n] = 8'(b[n]);
      for (int i = 0; i < NI; i++) weights_HL[n][i] = 8'(w[n][i]);
    end
  endtask

  task automatic fill(input int wv, input int bv, input int av);
    for (int n = 0; n < NO; n++) begin
      b[n] = bv;
      for (int i = 0; i < NI; i++) w[n][i] = wv;
    end
    for (int i = 0; i < NI; i++) a[i] = av;
  endtask

  task automatic send_acts(input bit gaps);
    for (int i = 0; i < NI; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          act_valid = 1'b0;
          act_in    = 8'($urandom);
          @(posedge clk); #1;
        end
      end
      act_valid = 1'b1;
      act_in    = 8'(a[i]);
      @(posedge clk); #1;
    end
    act_valid = 1'b0;
  endtask

  // Counts edges from the last accepted activation to out_valid.
  task automatic wait_out(input bit junk);
    cyc        = 0;
    seen_ready = 1'b0;
    seen_idle  = 1'b0;
    while (!out_valid && cyc < 400) begin
      if (junk) begin
        act_valid = 1'b1;
        act_in    = 8'($urandom);
      end
      @(posedge clk); #1;
      cyc++;
      seen_ready |= act_ready;
      seen_idle  |= !busy;
    end
    act_valid = 1'b0;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (act_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b valid=%b busy=%b, want 1 0 0",
               act_ready, out_valid, busy);
    end
    checks++;
    if (scores !== '0 || digit !== 4'd0) begin
      errors++;
      $display("FAIL reset_data: scores=%h digit=%0d, want 0 0", scores, digit);
    end
  endtask

  task automatic test_bias_only();
    fill(0, 0, 0);
    for (int n = 0; n < NO; n++) b[n] = n;
    for (int i = 0; i < NI; i++) a[i] = rnd8();
    model();
    load_ports();
    send_acts(1'b0);
    wait_out(1'b0);
    checks++;
    if (cyc !== 310) begin
      errors++;
      $display("FAIL bias_latency: got %0d edges, want 310", cyc);
    end
    for (int n = 0; n < NO; n++) begin
      checks++;
      if (got_score(n) !== n * 16) begin
        errors++;
        $display("FAIL bias_score[%0d]: got %0d want %0d", n, got_score(n), n * 16);
      end
    end
    checks++;
    if (digit !== 4'd9) begin
      errors++;
      $display("FAIL bias_digit: got %0d want 9", digit);
    end
    release_out();
    checks++;
    if (out_valid !== 1'b0 || act_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL handoff: valid=%b ready=%b busy=%b, want 0 1 0",
               out_valid, act_ready, busy);
    end
  endtask

  task automatic setup_one_hot();
    fill(0, 0, 16);
    for (int i = 0; i < NI; i++) w[3][i] = 16;
    model();
    load_ports();
  endtask

  task automatic test_one_hot();
    setup_one_hot();
    checks++;
    if (exp_s[3] !== 7680 || exp_d !== 3) begin
      errors++;
      $display("FAIL onehot_model: got %0d/%0d want 7680/3", exp_s[3], exp_d);
    end
    send_acts(1'b0);
    wait_out(1'b0);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL onehot_valid: got %b want 1", out_valid);
    end
    for (int n = 0; n < NO; n++) begin
      checks++;
      if (got_score(n) !== exp_s[n]) begin
        errors++;
        $display("FAIL onehot_score[%0d]: got %0d want %0d", n, got_score(n), exp_s[n]);
      end
    end
    checks++;
    if (digit !== 4'(exp_d)) begin
      errors++;
      $display("FAIL onehot_digit: got %0d want %0d", digit, exp_d);
    end
    release_out();
  endtask

  task automatic test_zero_tie();
    fill(0, 0, 0);
    model();
    load_ports();
    send_acts(1'b0);
    wait_out(1'b0);
    checks++;
    if (out_valid !== 1'b1 || scores !== '0) begin
      errors++;
      $display("FAIL zero_scores: valid=%b scores=%h want 1 0", out_valid, scores);
    end
    checks++;
    if (digit !== 4'd0) begin
      errors++;
      $display("FAIL zero_digit: got %0d want 0", digit);
    end
    release_out();
  endtask

  task automatic test_extreme();
    fill(-128, -128, -128);
    model();
    load_ports();
    send_acts(1'b0);
    wait_out(1'b0);
    for (int n = 0; n < NO; n++) begin
      checks++;
      if (got_score(n) !== 489472) begin
        errors++;
        $display("FAIL extreme_score[%0d]: got %0d want 489472", n, got_score(n));
      end
    end
    checks++;
    if (digit !== 4'd0) begin
      errors++;
      $display("FAIL extreme_digit: got %0d want 0", digit);
    end
    release_out();
  endtask

  task automatic test_reset_mid_mac();
    fill(0, 0, 0);
    for (int n = 0; n < NO; n++) begin
      b[n] = rnd8();
      for (int i = 0; i < NI; i++) w[n][i] = rnd8();
    end
    for (int i = 0; i < NI; i++) a[i] = rnd8();
    load_ports();
    send_acts(1'b0);
    repeat (150) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || act_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ctrl: valid=%b ready=%b busy=%b, want 0 1 0",
               out_valid, act_ready, busy);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (400) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_stale: out_valid=%b want 0", out_valid);
        break;
      end
    end
    setup_one_hot();
    send_acts(1'b0);
    wait_out(1'b0);
    checks++;
    if (got_score(3) !== 7680 || digit !== 4'd3 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL midreset_fresh: score3=%0d digit=%0d valid=%b want 7680 3 1",
               got_score(3), digit, out_valid);
    end
    release_out();
  endtask

  task automatic test_gaps_backpressure();
    logic [NO-1:0][23:0] snap_s;
    logic [3:0]          snap_d;
    bit                  stable;
    setup_one_hot();
    send_acts(1'b1);
    wait_out(1'b1);
    checks++;
    if (seen_ready !== 1'b0 || seen_idle !== 1'b0) begin
      errors++;
      $display("FAIL gaps_busy: ready_seen=%b idle_seen=%b want 0 0",
               seen_ready, seen_idle);
    end
    for (int n = 0; n < NO; n++) begin
      checks++;
      if (got_score(n) !== exp_s[n]) begin
        errors++;
        $display("FAIL gaps_score[%0d]: got %0d want %0d", n, got_score(n), exp_s[n]);
      end
    end
    snap_s = scores;
    snap_d = digit;
    stable = 1'b1;
    repeat (20) begin
      act_valid = 1'b1;
      act_in    = 8'($urandom);
      @(posedge clk); #1;
      if (scores !== snap_s || digit !== snap_d ||
          out_valid !== 1'b1 || act_ready !== 1'b0)
        stable = 1'b0;
    end
    act_valid = 1'b0;
    checks++;
    if (stable !== 1'b1 || snap_d !== 4'd3) begin
      errors++;
      $display("FAIL gaps_hold: stable=%b digit=%0d want 1 3", stable, snap_d);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 4; t++) begin
      for (int n = 0; n < NO; n++) begin
        b[n] = rnd8();
        for (int i = 0; i < NI; i++) w[n][i] = rnd8();
      end
      for (int i = 0; i < NI; i++) a[i] = rnd8();
      if (t == 3) begin
        for (int i = 0; i < NI; i++) w[7][i] = w[2][i];
        b[7] = b[2];
      end
      model();
      load_ports();
      send_acts(t[0]);
      wait_out(1'b0);
      for (int n = 0; n < NO; n++) begin
        checks++;
        if (got_score(n) !== exp_s[n]) begin
          errors++;
          $display("FAIL rand%0d_score[%0d]: got %0d want %0d",
                   t, n, got_score(n), exp_s[n]);
        end
      end
      checks++;
      if (digit !== 4'(exp_d) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rand%0d_digit: got %0d valid=%b want %0d 1",
                 t, digit, out_valid, exp_d);
      end
      release_out();
      checks++;
      if (got_score(0) !== exp_s[0]) begin
        errors++;
        $display("FAIL rand%0d_retain: got %0d want %0d", t, got_score(0), exp_s[0]);
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    act_in     = '0;
    act_valid  = 1'b0;
    out_ready  = 1'b0;
    weights_HL = '0;
    biases_HL  = '0;
    #2;
    test_reset();
    test_bias_only();
    test_one_hot();
    test_zero_tie();
    test_extreme();
    test_reset_mid_mac();
    test_gaps_backpressure();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
